uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter that sits on the data-memory bus beside the data Memory.
- Turns CPU byte stores to the console address into 8N1 serial frames on a txd pin.
- Buffers stores in a small FIFO so the CPU is never stalled.
- Exposes a readable status word so firmware can poll for space or idle.

---
 rtl/uart_tx_mmio_pkg.sv | 19 +
 rtl/uart_tx_fifo.sv | 35 +++
 rtl/uart_tx_mmio.sv | 84 ++++++++
 tb/tb_uart_tx_mmio.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_mmio_pkg.sv
// uart_tx_mmio_pkg: register offsets, status bit positions, FSM states and status word packing
package uart_tx_mmio_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} tx_state_t;
  localparam logic [31:0] DATA_OFS = 32'd0;
  localparam logic [31:0] STAT_OFS = 32'd4;
  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF = 3;
  function automatic logic [31:0] status_word(input logic ovf, input logic empty, input logic full, input logic busy);
    logic [31:0] s;
    s = '0;
    s[ST_OVF] = ovf;
    s[ST_EMPTY] = empty;
    s[ST_FULL] = full;
    s[ST_BUSY] = busy;
    return s;
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO with wrapping pointers and occupancy count
module uart_tx_fifo #(
  parameter int FIFO_AW = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             full,
  output logic             empty,
  output logic [FIFO_AW:0] count
);
  localparam int CW = FIFO_AW + 1;
  logic [7:0] mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + FIFO_AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + FIFO_AW'(1) : rd_ptr;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign dout = mem[rd_ptr];
  assign full = count == CW'(2**FIFO_AW);
  assign empty = count == '0;
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with store FIFO and pollable status word
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hf0000010,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_AW      = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [2:0]  func3,
  input  logic        write,
  input  logic [31:0] dataCOut,
  output logic [31:0] dataCIn,
  output logic        txd,
  output logic        busy
);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = FIFO_AW + 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  tx_state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n, dout;
  logic [CW-1:0] count, count_n;
  logic is_data, is_stat, tick, pop, push, full, empty, ovf, ovf_n, txd_n, busy_n;
  logic unused_bits;
  assign unused_bits = ^{func3, dataCOut[31:8]};
  assign is_data = address == BASE_ADDR + DATA_OFS;
  assign is_stat = address == BASE_ADDR + STAT_OFS;
  uart_tx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (dataCOut[7:0]),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  always_comb begin
    tick = baud == '0;
    pop = !empty && (state == IDLE || (state == STOP && tick));
    push = write && is_data && (!full || pop);
    state_n = state;
    case (state)
      IDLE:    state_n = pop ? START : IDLE;
      START:   state_n = tick ? DATA : START;
      DATA:    state_n = (tick && idx == 3'd7) ? STOP : DATA;
      STOP:    state_n = !tick ? STOP : pop ? START : IDLE;
      default: state_n = IDLE;
    endcase
    baud_n = (state == IDLE || tick) ? BAUD_MAX : baud - BW'(1);
    idx_n = (state == START) ? 3'd0 : (state == DATA && tick) ? idx + 3'd1 : idx;
    sh_n = pop ? dout : (state == DATA && tick) ? sh >> 1 : sh;
    txd_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? sh_n[0] : 1'b1;
    count_n = count + CW'(push) - CW'(pop);
    busy_n = state_n != IDLE || count_n != '0;
    ovf_n = (write && is_data && full && !pop) ? 1'b1 : (write && is_stat) ? 1'b0 : ovf;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      baud <= '0;
      idx <= '0;
      sh <= '0;
      txd <= 1'b1;
      busy <= 1'b0;
      ovf <= 1'b0;
      dataCIn <= '0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      idx <= idx_n;
      sh <= sh_n;
      txd <= txd_n;
      busy <= busy_n;
      ovf <= ovf_n;
      dataCIn <= is_stat ? status_word(ovf, empty, full, busy) : '0;
    end
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: vector table, corner sequences and random traffic against a frame-level model
module tb_uart_tx_mmio;
  localparam int C = 4;
  localparam logic [31:0] DA = 32'hf0000010;
  localparam logic [31:0] SA = 32'hf0000014;
  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        exp_txd;
    logic        exp_busy;
    logic [31:0] exp_rd;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic write = 1'b0;
  logic [2:0] func3 = 3'd0;
  logic [31:0] address = 32'd0;
  logic [31:0] dataCOut = 32'd0;
  logic [31:0] dataCIn;
  logic txd, busy;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] mq[$];
  logic in_frame = 1'b0;
  logic ovf_m = 1'b0;
  int f_start = 0;
  logic [7:0] f_byte = 8'h0;
  logic wire_q[$];
  logic busy_q[$];
  logic [7:0] dec_q[$];
  vec_t vt[7];
  uart_tx_mmio #(.BASE_ADDR(DA), .CLKS_PER_BIT(C), .FIFO_AW(3)) dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .func3    (func3),
    .write    (write),
    .dataCOut (dataCOut),
    .dataCIn  (dataCIn),
    .txd      (txd),
    .busy     (busy)
  );
  always #5 clock = ~clock;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  task automatic step(input logic rn, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] exp_rd;
    logic do_pop, end_edge, exp_txd, exp_busy;
    logic [9:0] fr;
    int sz;
    reset = rn;
    write = w;
    address = a;
    dataCOut = d;
    func3 = 3'($urandom_range(0, 7));
    exp_rd = (a == SA) ? {28'b0, ovf_m, mq.size() == 0, mq.size() == 8, in_frame || mq.size() != 0} : 32'b0;
    @(posedge clock);
    cyc++;
    if (!rn) begin
      mq.delete();
      in_frame = 1'b0;
      ovf_m = 1'b0;
      exp_rd = 32'b0;
    end else begin
      sz = mq.size();
      end_edge = in_frame && cyc == f_start + 10 * C;
      do_pop = sz != 0 && (!in_frame || end_edge);
      if (end_edge) in_frame = 1'b0;
      if (do_pop) begin
        f_byte = mq.pop_front();
        f_start = cyc;
        in_frame = 1'b1;
      end
      if (w && a == DA && (sz < 8 || do_pop)) mq.push_back(d[7:0]);
      if (w && a == DA && sz == 8 && !do_pop) ovf_m = 1'b1;
      else if (w && a == SA) ovf_m = 1'b0;
    end
    #1;
    fr = {1'b1, f_byte, 1'b0};
    exp_txd = in_frame ? fr[(cyc - f_start) / C] : 1'b1;
    exp_busy = in_frame || mq.size() != 0;
    check("txd", 32'(txd), 32'(exp_txd));
    check("busy", 32'(busy), 32'(exp_busy));
    check("dataCIn", dataCIn, exp_rd);
    wire_q.push_back(txd);
    busy_q.push_back(busy);
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 32'h0, 32'h0);
  endtask
  task automatic clear_log();
    wire_q.delete();
    busy_q.delete();
  endtask
  task automatic decode();
    int i;
    int p;
    logic [7:0] b;
    dec_q.delete();
    i = 1;
    while (i < wire_q.size()) begin
      if (wire_q[i] == 1'b0 && wire_q[i-1] == 1'b1) begin
        b = 8'h0;
        for (int k = 0; k < 8; k++) begin
          p = i + C * (k + 1) + C / 2;
          b[k] = (p < wire_q.size()) ? wire_q[p] : 1'b1;
        end
        dec_q.push_back(b);
        i = i + 10 * C - C / 2;
      end else i++;
    end
  endtask
  task automatic check_decoded(input string nm, input logic [7:0] first, input int n);
    decode();
    check({nm, "_count"}, 32'(dec_q.size()), 32'(n));
    for (int k = 0; k < n && k < dec_q.size(); k++) check({nm, "_byte"}, 32'(dec_q[k]), 32'(first + 8'(k)));
  endtask
  initial begin
    int s;
    int b;
    int g;
    int zeros;
    int dens;
    logic [31:0] a;
    step(1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rd", dataCIn, 32'd0);
    vt[0] = '{1'b0, SA, 32'h0, 1'b1, 1'b0, 32'h4};
    vt[1] = '{1'b1, SA, 32'h0, 1'b1, 1'b0, 32'h4};
    vt[2] = '{1'b0, DA, 32'h0, 1'b1, 1'b0, 32'h0};
    vt[3] = '{1'b0, 32'h12345678, 32'h0, 1'b1, 1'b0, 32'h0};
    vt[4] = '{1'b1, DA, 32'h41, 1'b1, 1'b1, 32'h0};
    vt[5] = '{1'b0, SA, 32'h0, 1'b0, 1'b1, 32'h1};
    vt[6] = '{1'b0, SA, 32'h0, 1'b0, 1'b1, 32'h5};
    clear_log();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, vt[i].w, vt[i].a, vt[i].d);
      check($sformatf("vec%0d_txd", i), 32'(txd), 32'(vt[i].exp_txd));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].exp_busy));
      check($sformatf("vec%0d_rd", i), dataCIn, vt[i].exp_rd);
    end
    idle(45);
    check_decoded("single", 8'h41, 1);
    s = 0;
    while (s < wire_q.size() && wire_q[s] != 1'b0) s++;
    b = s;
    while (b < busy_q.size() && busy_q[b] != 1'b0) b++;
    check("frame_len", 32'(b - s), 32'd40);
    clear_log();
    step(1'b1, 1'b1, DA, 32'h48);
    step(1'b1, 1'b1, DA, 32'h69);
    idle(90);
    decode();
    check("b2b_count", 32'(dec_q.size()), 32'd2);
    if (dec_q.size() == 2) begin
      check("b2b_first", 32'(dec_q[0]), 32'h48);
      check("b2b_second", 32'(dec_q[1]), 32'h69);
    end
    s = 0;
    while (s < wire_q.size() && wire_q[s] != 1'b0) s++;
    check("b2b_stop_end", 32'(wire_q[s + 39]), 32'd1);
    check("b2b_no_gap", 32'(wire_q[s + 40]), 32'd0);
    clear_log();
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, DA, 32'h30 + 32'(k));
    step(1'b1, 1'b0, SA, 32'h0);
    check("ovf_full_bit", 32'(dataCIn[1]), 32'd1);
    check("ovf_bit", 32'(dataCIn[3]), 32'd1);
    step(1'b1, 1'b1, SA, 32'h0);
    step(1'b1, 1'b0, SA, 32'h0);
    check("ovf_cleared", 32'(dataCIn[3]), 32'd0);
    idle(370);
    check_decoded("fill", 8'h30, 9);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    clear_log();
    for (int k = 0; k < 9; k++) step(1'b1, 1'b1, DA, 32'h60 + 32'(k));
    g = 0;
    while (cyc + 1 != f_start + 10 * C && g < 100) begin
      idle(1);
      g++;
    end
    check("wait_stop_end", 32'(g < 100), 32'd1);
    step(1'b1, 1'b1, DA, 32'h69);
    step(1'b1, 1'b0, SA, 32'h0);
    check("pushpop_status", dataCIn, 32'h3);
    idle(410);
    check_decoded("pushpop", 8'h60, 10);
    clear_log();
    step(1'b1, 1'b1, DA, 32'h55);
    step(1'b1, 1'b1, DA, 32'hA1);
    step(1'b1, 1'b1, DA, 32'hA2);
    g = 0;
    while (!(in_frame && (cyc - f_start) / C == 4) && g < 100) begin
      idle(1);
      g++;
    end
    check("wait_bit3", 32'(g < 100), 32'd1);
    check("bit3_value", 32'(txd), 32'd0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    check("midreset_txd", 32'(txd), 32'd1);
    check("midreset_busy", 32'(busy), 32'd0);
    step(1'b1, 1'b0, SA, 32'h0);
    check("midreset_status", dataCIn, 32'h4);
    clear_log();
    idle(100);
    zeros = 0;
    foreach (wire_q[k]) if (wire_q[k] != 1'b1) zeros++;
    check("midreset_silent", 32'(zeros), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      dens = (i / 500) % 3 == 0 ? 3 : (i / 500) % 3 == 1 ? 15 : 50;
      g = $urandom_range(0, 9);
      a = g < 6 ? DA : g < 8 ? SA : $urandom;
      step($urandom_range(0, 599) != 0, $urandom_range(0, 99) < dens, a, $urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
